pc_branch_unit: RTL and testbench
=================================

Name: pc_branch_unit

Overview:
- Fetch-side control stage for the accumulator datapath.
- Latches the ALU's z/c/n/v flags into a flag register and resolves conditional branches against them.
- Drives the program counter that feeds instruction fetch.
- Handles start/halt sequencing; branch targets come from a small loadable target LUT.

Parameters:
- PC_W, 10, program counter width; address space 0..2^PC_W-1.
- LUT_DEPTH, 16, number of branch-target LUT entries; index width is $clog2(LUT_DEPTH).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin execution at start_addr (pulse)
- start_addr  in  PC_W  initial PC loaded on start
- stall  in  1  freeze PC and state this cycle
- halt  in  1  current instruction is HALT
- br_valid  in  1  current instruction is a branch
- br_cond  in  4  branch condition code
- br_idx  in  $clog2(LUT_DEPTH)  target LUT index
- flag_we  in  1  capture ALU flags this cycle
- z_in, c_in, n_in, v_in  in  1 each  ALU flag outputs
- lut_we  in  1  LUT write enable
- lut_addr  in  $clog2(LUT_DEPTH)  LUT write index
- lut_data  in  PC_W  LUT write data
- pc  out  PC_W  current program counter
- running  out  1  high in RUN state
- done  out  1  high in HALTED state
- flags  out  4  registered {z,c,n,v}
- br_taken  out  1  combinational: branch resolves taken this cycle

Behaviour:
- Reset (async, rst_n=0): pc=0, state=IDLE, flags=4'b0000, all LUT entries=0. running=0, done=0. Stats counters (if built) = 0.
- States: IDLE, RUN, HALTED. running=(state==RUN); done=(state==HALTED).
- IDLE/HALTED with start=1: next edge pc<=start_addr, state<=RUN, done clears.
- start in RUN is ignored.
- RUN with stall=1: pc, state and flags hold. LUT writes still occur.
- RUN with stall=0, priority:
  - halt=1: state<=HALTED, pc holds (points at HALT).
  - else br_valid=1 and taken: pc<=lut[br_idx].
  - else: pc<=pc+1, wrapping 2^PC_W-1 -> 0.
- Conditions are evaluated on the registered flags, never on z_in etc. in the same cycle. A compare followed by a branch in the next instruction therefore sees the new flags.
- Condition codes:
  - 0000 always; 0001 Z; 0010 !Z; 0011 N (lt); 0100 !N&!Z (gt); 0101 N|Z (le); 0110 C; 0111 V.
  - 1000-1111 never taken.
- br_taken = state==RUN & !stall & !halt & br_valid & cond_true. It is 0 otherwise.
- Flag register: when flag_we=1 and (state!=RUN or stall=0), flags<={z_in,c_in,n_in,v_in} on the edge. A simultaneous branch uses the old flags.
- LUT: synchronous write on lut_we in any state. A write and a read of the same entry in one cycle returns the old entry to the branch.
- halt and br_valid both high: halt wins; branch not taken.

Optional Feature:
- Macro: PC_BRANCH_STATS_EN.
- Defined:
  - Adds 16-bit outputs br_count (branches executed) and taken_count (branches taken).
  - Each increments on RUN & !stall & !halt & br_valid, and saturates at 16'hFFFF.
  - Both clear on reset and on an accepted start.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package pc_pkg:
  - brcond_e enum for the condition codes.
  - pc_state_e enum {IDLE,RUN,HALTED}.
  - Flag-bit index constants FLAG_Z/C/N/V.
- One sub-module: branch_cond_eval. Combinational, takes 4-bit flags and br_cond, returns cond_true.

Test Plan:
- Reset, then start=1 with start_addr=10'h040 -> next cycle pc=0x040, running=1. Three free cycles -> pc=0x043.
- Load lut[3]=0x120. flag_we with z_in=1. Next cycle br_valid, br_cond=0001, br_idx=3 -> br_taken=1, pc=0x120. Repeat with br_cond=0010 -> pc+1.
- Same-cycle flag_we (z_in=1) and branch cond 0001 with flags previously 0 -> not taken, pc+1; flags=1000 afterwards.
- pc=0x3FF, no branch -> pc wraps to 0x000. stall=1 for 2 cycles -> pc holds.
- halt with br_valid, cond 0000 -> done=1, running=0, pc holds. start with start_addr=0x010 -> RUN at 0x010. rst_n low mid-run -> pc=0, IDLE, flags=0 immediately.
- With PC_BRANCH_STATS_EN: 5 branches, 2 taken -> br_count=5, taken_count=2. Restart -> both 0.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the fetch-side PC/branch unit.
package pc_pkg;
    typedef enum logic [3:0] {
        COND_AL = 4'b0000,
        COND_EQ = 4'b0001,
        COND_NE = 4'b0010,
        COND_LT = 4'b0011,
        COND_GT = 4'b0100,
        COND_LE = 4'b0101,
        COND_CS = 4'b0110,
        COND_VS = 4'b0111
    } brcond_e;

    typedef enum logic [1:0] {IDLE, RUN, HALTED} pc_state_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: resolves a branch condition code against {z,c,n,v}; codes 8-15 never take.
module branch_cond_eval
    import pc_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] br_cond,
    output logic       cond_true
);
    always_comb begin
        cond_true = 1'b0;
        case (br_cond)
            COND_AL: cond_true = 1'b1;
            COND_EQ: cond_true = flags[FLAG_Z];
            COND_NE: cond_true = !flags[FLAG_Z];
            COND_LT: cond_true = flags[FLAG_N];
            COND_GT: cond_true = !flags[FLAG_N] && !flags[FLAG_Z];
            COND_LE: cond_true = flags[FLAG_N] || flags[FLAG_Z];
            COND_CS: cond_true = flags[FLAG_C];
            COND_VS: cond_true = flags[FLAG_V];
            default: cond_true = 1'b0;
        endcase
    end
endmodule

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: program counter, flag register, branch-target LUT and start/halt sequencing.
// Optional branch statistics counters are built when PC_BRANCH_STATS_EN is defined.
module pc_branch_unit
    import pc_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int LUT_DEPTH = 16,
    localparam int IDX_W    = $clog2(LUT_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PC_W-1:0]  start_addr,
    input  logic             stall,
    input  logic             halt,
    input  logic             br_valid,
    input  logic [3:0]       br_cond,
    input  logic [IDX_W-1:0] br_idx,
    input  logic             flag_we,
    input  logic             z_in,
    input  logic             c_in,
    input  logic             n_in,
    input  logic             v_in,
    input  logic             lut_we,
    input  logic [IDX_W-1:0] lut_addr,
    input  logic [PC_W-1:0]  lut_data,
    output logic [PC_W-1:0]  pc,
    output logic             running,
    output logic             done,
    output logic [3:0]       flags,
    output logic             br_taken
`ifdef PC_BRANCH_STATS_EN
    ,
    output logic [15:0]      br_count,
    output logic [15:0]      taken_count
`endif
);
    pc_state_e       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [3:0]      flags_q, flags_d;
    logic [PC_W-1:0] lut_q [LUT_DEPTH];
    logic [PC_W-1:0] lut_d [LUT_DEPTH];
    logic            cond_true, active, start_acc;

    branch_cond_eval u_cond (
        .flags     (flags_q),
        .br_cond   (br_cond),
        .cond_true (cond_true)
    );

    assign active    = state_q == RUN && !stall;
    assign start_acc = state_q != RUN && start;
    assign br_taken  = active && !halt && br_valid && cond_true;
    assign pc        = pc_q;
    assign flags     = flags_q;
    assign running   = state_q == RUN;
    assign done      = state_q == HALTED;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flags_d = flags_q;
        lut_d   = lut_q;
        if (start_acc) begin
            state_d = RUN;
            pc_d    = start_addr;
        end else if (active) begin
            state_d = halt ? HALTED : RUN;
            pc_d    = halt ? pc_q : br_taken ? lut_q[br_idx] : pc_q + 1'b1;
        end
        // Branches above read flags_q/lut_q, so same-cycle updates are seen only next cycle.
        if (flag_we && (state_q != RUN || !stall)) begin
            flags_d[FLAG_Z] = z_in;
            flags_d[FLAG_C] = c_in;
            flags_d[FLAG_N] = n_in;
            flags_d[FLAG_V] = v_in;
        end
        if (lut_we) lut_d[lut_addr] = lut_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            flags_q <= '0;
            lut_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flags_q <= flags_d;
            lut_q   <= lut_d;
        end
    end

`ifdef PC_BRANCH_STATS_EN
    logic [15:0] br_cnt_q, br_cnt_d, tk_cnt_q, tk_cnt_d;
    logic        br_exec;

    assign br_exec     = active && !halt && br_valid;
    assign br_count    = br_cnt_q;
    assign taken_count = tk_cnt_q;

    always_comb begin
        br_cnt_d = start_acc ? '0 : (br_exec && br_cnt_q != 16'hFFFF) ? br_cnt_q + 1'b1 : br_cnt_q;
        tk_cnt_d = start_acc ? '0 : (br_taken && tk_cnt_q != 16'hFFFF) ? tk_cnt_q + 1'b1 : tk_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q <= '0;
            tk_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            tk_cnt_q <= tk_cnt_d;
        end
    end
`endif
endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: scoreboard bench; expected PC/state/flags are queued at drive time and popped after the edge.
module tb_pc_branch_unit;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stall, halt, br_valid, flag_we, z_in, c_in, n_in, v_in, lut_we;
    logic [9:0] start_addr, lut_data;
    logic [3:0] br_cond, br_idx, lut_addr;
    logic [9:0] pc;
    logic       running, done, br_taken;
    logic [3:0] flags;
`ifdef PC_BRANCH_STATS_EN
    logic [15:0] br_count, taken_count;
`endif

    typedef struct packed {
        logic [9:0] pc;
        logic       running;
        logic       done;
        logic [3:0] flags;
    } exp_t;

    exp_t       sb [$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         m_state;
    logic [9:0] m_pc;
    logic [3:0] m_flags;
    logic [9:0] m_lut [16];

    always #5 clk = ~clk;

    pc_branch_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .stall(stall),
        .halt(halt), .br_valid(br_valid), .br_cond(br_cond), .br_idx(br_idx),
        .flag_we(flag_we), .z_in(z_in), .c_in(c_in), .n_in(n_in), .v_in(v_in),
        .lut_we(lut_we), .lut_addr(lut_addr), .lut_data(lut_data),
        .pc(pc), .running(running), .done(done), .flags(flags), .br_taken(br_taken)
`ifdef PC_BRANCH_STATS_EN
        , .br_count(br_count), .taken_count(taken_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // flags layout {z,c,n,v}
    function automatic logic cond_ok(input logic [3:0] f, input logic [3:0] c);
        case (c)
            4'd0: return 1'b1;
            4'd1: return f[3];
            4'd2: return !f[3];
            4'd3: return f[1];
            4'd4: return !f[1] && !f[3];
            4'd5: return f[1] || f[3];
            4'd6: return f[2];
            4'd7: return f[0];
            default: return 1'b0;
        endcase
    endfunction

    task automatic clr();
        start = 0; stall = 0; halt = 0; br_valid = 0; flag_we = 0; lut_we = 0;
        z_in = 0; c_in = 0; n_in = 0; v_in = 0;
        start_addr = '0; lut_data = '0; br_cond = '0; br_idx = '0; lut_addr = '0;
    endtask

    task automatic model_reset();
        m_state = 0; m_pc = '0; m_flags = '0;
        for (int i = 0; i < 16; i++) m_lut[i] = '0;
    endtask

    // Inputs must already be driven; called at posedge+1.
    task automatic cycle();
        logic tk;
        logic fl_ok;
        exp_t e;
        #1;
        tk = (m_state == 1) && !stall && !halt && br_valid && cond_ok(m_flags, br_cond);
        check("br_taken", br_taken, tk);
        fl_ok = flag_we && (m_state != 1 || !stall);
        if (m_state != 1 && start) begin
            m_state = 1; m_pc = start_addr;
        end else if (m_state == 1 && !stall) begin
            if (halt) m_state = 2;
            else if (tk) m_pc = m_lut[br_idx];
            else m_pc = m_pc + 10'd1;
        end
        if (fl_ok) m_flags = {z_in, c_in, n_in, v_in};
        if (lut_we) m_lut[lut_addr] = lut_data;
        e.pc = m_pc; e.running = m_state == 1; e.done = m_state == 2; e.flags = m_flags;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("pc", pc, e.pc);
            check("running", running, e.running);
            check("done", done, e.done);
            check("flags", flags, e.flags);
        end
    endtask

    task automatic branch(input logic [3:0] c, input logic [3:0] idx);
        clr(); br_valid = 1; br_cond = c; br_idx = idx;
        cycle();
    endtask

    initial begin
        clr();
        model_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        check("rst_pc", pc, 0);
        check("rst_running", running, 0);
        check("rst_done", done, 0);
        check("rst_flags", flags, 0);

        // start and free run
        clr(); start = 1; start_addr = 10'h040; cycle();
        check("start_pc", pc, 10'h040);
        check("start_running", running, 1);
        clr(); repeat (3) cycle();
        check("run3_pc", pc, 10'h043);
        clr(); start = 1; start_addr = 10'h155; cycle();
        check("start_in_run_ignored", pc, 10'h044);

        // LUT load and flag capture, then branch on registered Z
        clr(); lut_we = 1; lut_addr = 4'd3; lut_data = 10'h120; flag_we = 1; z_in = 1; cycle();
        branch(4'd1, 4'd3);
        check("beq_taken_pc", pc, 10'h120);
        branch(4'd2, 4'd3);
        check("bne_fall_pc", pc, 10'h121);

        // same-cycle flag write is not seen by the branch
        clr(); flag_we = 1; cycle();
        clr(); flag_we = 1; z_in = 1; br_valid = 1; br_cond = 4'd1; br_idx = 4'd3; cycle();
        check("same_cycle_flag_pc", pc, 10'h123);
        check("same_cycle_flag_flags", flags, 4'b1000);

        // wrap at top of address space
        clr(); lut_we = 1; lut_addr = 4'd5; lut_data = 10'h3FE; cycle();
        branch(4'd0, 4'd5);
        clr(); cycle();
        check("pc_3ff", pc, 10'h3FF);
        clr(); cycle();
        check("pc_wrap", pc, 10'h000);

        // stall holds pc/flags; LUT still writes; stalled branch not taken
        clr(); stall = 1; flag_we = 1; c_in = 1; v_in = 1; lut_we = 1; lut_addr = 4'd7; lut_data = 10'h2AA; cycle();
        clr(); stall = 1; br_valid = 1; br_cond = 4'd0; cycle();
        check("stall_pc", pc, 10'h000);
        check("stall_flags", flags, 4'b1000);

        // halt beats branch
        clr(); halt = 1; br_valid = 1; br_cond = 4'd0; br_idx = 4'd7; cycle();
        check("halt_done", done, 1);
        check("halt_running", running, 0);
        check("halt_pc", pc, 10'h000);
        clr(); repeat (2) cycle();
        clr(); start = 1; start_addr = 10'h010; cycle();
        check("restart_pc", pc, 10'h010);
        check("restart_done", done, 0);
        branch(4'd0, 4'd7);
        check("stalled_lut_write", pc, 10'h2AA);

        // condition code sweep with assorted flag patterns
        for (int f = 0; f < 16; f += 5) begin
            clr(); flag_we = 1; {z_in, c_in, n_in, v_in} = 4'(f); cycle();
            for (int c = 0; c < 16; c++) branch(4'(c), 4'(c));
        end

`ifdef PC_BRANCH_STATS_EN
        clr(); halt = 1; cycle();
        clr(); start = 1; start_addr = 10'h080; cycle();
        check("stats_clr_br", br_count, 0);
        check("stats_clr_tk", taken_count, 0);
        branch(4'd0, 4'd3);
        branch(4'd8, 4'd3);
        branch(4'd0, 4'd3);
        branch(4'd15, 4'd3);
        branch(4'd9, 4'd3);
        clr(); stall = 1; br_valid = 1; cycle();
        check("stats_br", br_count, 5);
        check("stats_tk", taken_count, 2);
        clr(); halt = 1; br_valid = 1; cycle();
        check("stats_halt_br", br_count, 5);
        clr(); start = 1; start_addr = 10'h001; cycle();
        check("stats_restart_br", br_count, 0);
        check("stats_restart_tk", taken_count, 0);
`endif

        // random traffic against the model
        for (int i = 0; i < 300; i++) begin
            clr();
            stall = ($urandom_range(0, 3) == 0);
            halt = ($urandom_range(0, 30) == 0);
            start = (m_state != 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
            start_addr = 10'($urandom);
            br_valid = $urandom_range(0, 1);
            br_cond = 4'($urandom);
            br_idx = 4'($urandom);
            flag_we = $urandom_range(0, 1);
            {z_in, c_in, n_in, v_in} = 4'($urandom);
            lut_we = $urandom_range(0, 1);
            lut_addr = 4'($urandom);
            lut_data = 10'($urandom);
            cycle();
        end

        // asynchronous reset mid-run
        clr(); start = 1; start_addr = 10'h0F0; cycle();
        clr(); flag_we = 1; z_in = 1; n_in = 1; cycle();
        #2 rst_n = 0;
        #1;
        model_reset();
        check("async_rst_pc", pc, 0);
        check("async_rst_running", running, 0);
        check("async_rst_flags", flags, 0);
        check("async_rst_sb", sb.size(), 0);
        @(posedge clk);
        #1 rst_n = 1;
        clr(); branch(4'd0, 4'd7);
        check("post_rst_idle_pc", pc, 0);
        clr(); start = 1; start_addr = 10'h002; cycle();
        branch(4'd0, 4'd7);
        check("post_rst_lut_cleared", pc, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
